// File: rtl/moore_rr_arbiter_if.sv
// Request/grant bundle between four requesters and the
// round-robin arbiter.
interface moore_rr_arbiter_if;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       busy;
  logic [1:0] owner;
  logic       timeout;

  modport master (
    output en,
    output req,
    input  gnt,
    input  busy,
    input  owner,
    input  timeout
  );

  modport slave (
    input  en,
    input  req,
    output gnt,
    output busy,
    output owner,
    output timeout
  );
endinterface

// File: rtl/moore_rr_arbiter.sv
// Four-way round-robin Moore arbiter with a bounded hold
// time; all outputs come straight from flops.
module moore_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input logic               clk,
  input logic               rst,
  moore_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT  = 2'b01,
    REVOKE = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(MAX_HOLD - 1);

  state_t           state;
  logic [1:0]       owner;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       gnt;
  logic             busy;
  logic             timeout;

  logic [1:0] win;
  logic [1:0] idx;
  logic       arb;

  // Walk owner+4 down to owner+1 so the nearest
  // requester after the owner is written last and wins.
  always_comb begin
    win = owner;
    idx = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = owner + 2'(k);
      if (bus.req[idx]) win = idx;
    end
  end

  assign arb = bus.en && (bus.req != 4'b0000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner   <= 2'd3;
      cnt     <= '0;
      gnt     <= 4'b0000;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      unique case (state)
        IDLE, REVOKE: begin
          timeout <= 1'b0;
          if (arb) begin
            state <= GRANT;
            owner <= win;
            cnt   <= '0;
            gnt   <= 4'b0001 << win;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            gnt   <= 4'b0000;
            busy  <= 1'b0;
          end
        end
        GRANT: begin
          if (!bus.req[owner]) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            busy  <= 1'b0;
          end else if (cnt == HOLD_LAST) begin
            state   <= REVOKE;
            gnt     <= 4'b0000;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          gnt     <= 4'b0000;
          busy    <= 1'b0;
          timeout <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt;
  assign bus.busy    = busy;
  assign bus.owner   = owner;
  assign bus.timeout = timeout;

endmodule

// File: tb/tb_moore_rr_arbiter.sv
// Directed bench for moore_rr_arbiter: one instance with
// MAX_HOLD=8 and one with MAX_HOLD=2.
module tb_moore_rr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  moore_rr_arbiter_if a ();
  moore_rr_arbiter_if b ();

  moore_rr_arbiter #(
    .MAX_HOLD(8),
    .CNT_W   (8)
  ) dut8 (
    .clk(clk),
    .rst(rst),
    .bus(a)
  );

  moore_rr_arbiter #(
    .MAX_HOLD(2),
    .CNT_W   (8)
  ) dut2 (
    .clk(clk),
    .rst(rst),
    .bus(b)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a(input string tag);
    chk({tag, ".gnt"}, 32'(a.gnt), 32'h0);
    chk({tag, ".busy"}, 32'(a.busy), 32'h0);
    chk({tag, ".tmo"}, 32'(a.timeout), 32'h0);
  endtask

  initial begin
    logic [3:0] e;
    a.en  = 1'b1;
    a.req = 4'b0000;
    b.en  = 1'b1;
    b.req = 4'b0000;
    step();
    step();
    rst = 1'b0;
    idle_a("rst");
    chk("rst.owner", 32'(a.owner), 32'd3);
    step();
    idle_a("rst.hold");

    // single request, voluntary release after 3 cycles
    a.req = 4'b0100;
    step();
    chk("t2.gnt0", 32'(a.gnt), 32'h4);
    chk("t2.owner", 32'(a.owner), 32'd2);
    chk("t2.busy", 32'(a.busy), 32'h1);
    step();
    chk("t2.gnt1", 32'(a.gnt), 32'h4);
    step();
    chk("t2.gnt2", 32'(a.gnt), 32'h4);
    a.req = 4'b0000;
    step();
    idle_a("t2.rel");
    chk("t2.owner_kept", 32'(a.owner), 32'd2);

    // async reset in the middle of a grant
    a.req = 4'b0001;
    step();
    chk("t1.pre", 32'(a.gnt), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    idle_a("t1.async");
    chk("t1.owner", 32'(a.owner), 32'd3);
    a.req = 4'b0000;
    step();
    rst = 1'b0;
    step();
    step();
    idle_a("t1.after");

    // all request: 8 grant cycles, one revoke cycle
    a.req = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      e = 4'(1 << g);
      for (int c = 0; c < 8; c++) begin
        step();
        chk($sformatf("t3.g%0d.c%0d", g, c),
            32'(a.gnt), 32'(e));
      end
      chk($sformatf("t3.own%0d", g),
          32'(a.owner), 32'(g));
      step();
      chk($sformatf("t3.rv%0d.gnt", g),
          32'(a.gnt), 32'h0);
      chk($sformatf("t3.rv%0d.tmo", g),
          32'(a.timeout), 32'h1);
      chk($sformatf("t3.rv%0d.busy", g),
          32'(a.busy), 32'h0);
    end
    a.req = 4'b0000;
    step();
    idle_a("t3.end");
    chk("t3.owner", 32'(a.owner), 32'd3);

    // rotation after owner 0 releases
    a.req = 4'b0001;
    step();
    chk("t4.own0", 32'(a.gnt), 32'h1);
    a.req = 4'b0000;
    step();
    idle_a("t4.rel0");
    a.req = 4'b0011;
    step();
    chk("t4.pick1", 32'(a.gnt), 32'h2);
    chk("t4.owner1", 32'(a.owner), 32'd1);
    a.req = 4'b0001;
    step();
    idle_a("t4.gap");
    step();
    chk("t4.pick0", 32'(a.gnt), 32'h1);
    a.req = 4'b0000;
    step();
    idle_a("t4.end");

    // enable gates only new grants
    a.en  = 1'b0;
    a.req = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("t5.off%0d", c),
          32'(a.gnt), 32'h0);
    end
    a.en = 1'b1;
    step();
    chk("t5.on", 32'(a.gnt), 32'h8);
    chk("t5.owner", 32'(a.owner), 32'd3);
    a.en = 1'b0;
    for (int c = 1; c < 8; c++) begin
      step();
      chk($sformatf("t5.hold%0d", c),
          32'(a.gnt), 32'h8);
    end
    step();
    chk("t5.tmo", 32'(a.timeout), 32'h1);
    chk("t5.tmo_gnt", 32'(a.gnt), 32'h0);
    step();
    idle_a("t5.no_regrant");
    a.req = 4'b0000;
    a.en  = 1'b1;

    // sole requester with MAX_HOLD=2
    chk("t6.idle", 32'(b.gnt), 32'h0);
    b.req = 4'b0001;
    for (int p = 0; p < 3; p++) begin
      step();
      chk($sformatf("t6.p%0d.g0", p),
          32'(b.gnt), 32'h1);
      step();
      chk($sformatf("t6.p%0d.g1", p),
          32'(b.gnt), 32'h1);
      step();
      chk($sformatf("t6.p%0d.gap", p),
          32'(b.gnt), 32'h0);
      chk($sformatf("t6.p%0d.tmo", p),
          32'(b.timeout), 32'h1);
    end
    b.req = 4'b0000;
    step();
    chk("t6.end", 32'(b.gnt), 32'h0);

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule
